// File: rtl/adc_sample_fifo.sv
// Show-ahead sample FIFO between the ADC capture stage and the downstream filter.
// Rejected writes on a full FIFO are flagged by a sticky overflow bit and a saturating counter.
module adc_sample_fifo #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_ready,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        dropped
);

  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne    = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        dropped_q, dropped_d;

  logic wr_acc;
  logic wr_rej;
  logic rd_acc;

  // Status is decoded from the registered count only.
  assign full       = (count_q == FullCount);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign dout_valid = ~empty;
  assign dout       = mem_q[rd_ptr_q];
  assign overflow   = overflow_q;
  assign dropped    = dropped_q;

  assign wr_acc = wr_en & ~full;
  assign wr_rej = wr_en & full;
  assign rd_acc = rd_ready & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // A reject coinciding with a clear counts as the first drop after the clear.
  always_comb begin
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (clr_ovf) begin
      overflow_d = wr_rej;
      dropped_d  = wr_rej ? 8'd1 : 8'd0;
    end else if (wr_rej) begin
      overflow_d = 1'b1;
      if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  // Storage is not reset; a reset only discards contents via the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Randomised scoreboard bench for adc_sample_fifo: driver pushes expected samples,
// a negedge monitor pops them whenever the DUT hands a sample to the consumer.
module tb_adc_sample_fifo;

  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    dropped;

  adc_sample_fifo #(
    .DATA_W(DW),
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .din       (din),
    .rd_ready  (rd_ready),
    .clr_ovf   (clr_ovf),
    .dout      (dout),
    .dout_valid(dout_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of samples expected out, plus occupancy and drop bookkeeping.
  logic [DW-1:0] exp_q[$];
  int m_cnt  = 0;
  bit m_ovf  = 1'b0;
  int m_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a read happens at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && rd_ready && dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got 0x%0h, expected no sample at %0t", dout, $time);
      end else begin
        chk("dout_order", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_status();
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("dout_valid", 32'(dout_valid), 32'(m_cnt != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("dropped", 32'(dropped), 32'(m_drop));
    if (m_cnt > 0 && exp_q.size() > 0) chk("dout_head", 32'(dout), 32'(exp_q[0]));
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit ra, wa, wj;
    wr_en    = w;
    din      = d;
    rd_ready = r;
    clr_ovf  = c;
    ra = r && (m_cnt > 0);
    wa = w && (m_cnt < DEPTH);
    wj = w && (m_cnt == DEPTH);
    if (wa) exp_q.push_back(d);
    m_cnt = m_cnt + int'(wa) - int'(ra);
    if (c) begin
      m_ovf  = wj;
      m_drop = wj ? 1 : 0;
    end else if (wj) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic do_reset(input bit w, input int n);
    rst      = 1'b1;
    wr_en    = w;
    din      = DW'(12'h5A5);
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_en  = 1'b0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
    exp_q.delete();
    check_status();
  endtask

  initial begin
    // Reset then idle
    do_reset(1'b0, 2);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Single pass-through: visible right after the write edge
    step(1'b1, DW'(12'hABC), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill, two rejects, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, DW'(12'h011), 1'b0, 1'b0);
    step(1'b1, DW'(12'h012), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous read and write: write rejected, read proceeds
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(12'h100 + i), 1'b0, 1'b0);
    step(1'b1, DW'(12'h0FF), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Clear colliding with a reject, then a plain clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(12'h200 + i), 1'b0, 1'b0);
    step(1'b1, DW'(12'h3FF), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);

    // Reset wins over a simultaneous write
    do_reset(1'b1, 1);

    // Wrap-around streaming with the consumer always ready
    for (int i = 0; i < 40; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic in phases biased toward filling and draining
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 70; i++) begin
        bit w, r, c;
        w = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        r = (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 15) == 0);
        step(w, DW'($urandom), r, c);
      end
    end
    while (m_cnt > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_fifo.md
ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 Parameter DATA_W, default 12, SHALL set the sample width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the FIFO depth in entries (power of two).
REQ-003 Parameter ADDR_W, default 4, SHALL equal log2(DEPTH).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL be the one-cycle sample-ready pulse from the ADC capture stage.
REQ-007 din  input  DATA_W  SHALL be the sample captured when wr_en is high.
REQ-008 rd_ready  input  1  SHALL be the consumer (equalizer/filter) accept signal.
REQ-009 clr_ovf  input  1  SHALL clear the overflow flag and the drop counter.
REQ-010 dout  output  DATA_W  SHALL be the oldest stored sample.
REQ-011 dout_valid  output  1  SHALL indicate that dout holds a valid sample.
REQ-012 full  output  1  SHALL be high when count equals DEPTH.
REQ-013 empty  output  1  SHALL be high when count equals 0.
REQ-014 count  output  ADDR_W+1  SHALL be the number of stored samples, 0..DEPTH.
REQ-015 overflow  output  1  SHALL be a sticky flag for any rejected write.
REQ-016 dropped  output  8  SHALL be the number of rejected writes, saturating at 255.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_W array with ADDR_W-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-018 A write SHALL be accepted at an edge where wr_en=1 and full=0; din is stored at wr_ptr, and wr_ptr increments.
REQ-019 dout SHALL present mem[rd_ptr] combinationally (show-ahead); dout_valid SHALL equal !empty.
REQ-020 A read SHALL occur at an edge where dout_valid=1 and rd_ready=1; rd_ptr increments.
REQ-021 Latency: a sample written at edge N SHALL appear on dout with dout_valid=1 immediately after edge N when the FIFO was empty.
REQ-022 count SHALL change by +1 for a write alone, -1 for a read alone, and 0 for a simultaneous accepted write and read.
REQ-023 When full, wr_en=1 SHALL be rejected even if a read occurs in the same cycle; the read still proceeds, so count becomes DEPTH-1.
REQ-024 A rejected write SHALL set overflow=1 and increment dropped, which holds at 255.
REQ-025 When empty, rd_ready=1 SHALL have no effect; pointers and count hold.
REQ-026 clr_ovf=1 SHALL clear overflow to 0 and dropped to 0 at the next edge, unless a write is rejected at that same edge; in that case overflow=1 and dropped=1.
REQ-027 clr_ovf SHALL NOT affect stored data, pointers or count.
REQ-028 Samples SHALL leave the FIFO in write order with no duplication or loss except rejected writes.
REQ-029 full, empty and count SHALL be derived from registered state only, with no combinational path from wr_en or rd_ready.

Reset
REQ-030 At an edge with rst=1, wr_ptr, rd_ptr, count, overflow and dropped SHALL go to 0; empty=1, full=0, dout_valid=0.
REQ-031 rst SHALL take priority over wr_en, rd_ready and clr_ovf in the same cycle.
REQ-032 A reset during operation SHALL discard all stored samples; memory contents need not be cleared, and dout is don't-care while dout_valid=0.

Verification
REQ-033 Reset then idle: rst for 2 cycles, no stimulus -> count=0, empty=1, full=0, dout_valid=0, overflow=0, dropped=0.
REQ-034 Single pass-through: write 0xABC with rd_ready=0 -> after that edge dout=0xABC, dout_valid=1, count=1; then rd_ready=1 for one cycle -> empty=1.
REQ-035 Fill and overflow: write 0x001..0x010 (16 writes), then write 0x011 and 0x012 -> full=1, count=16, overflow=1, dropped=2; reading all 16 returns 0x001..0x010 in order.
REQ-036 Full with simultaneous read and write: when full, wr_en=1 with din=0x0FF and rd_ready=1 -> count=15, 0x0FF not stored, dropped increments by 1.
REQ-037 Wrap-around streaming: 40 writes with rd_ready=1 continuously -> every sample emerges in order, count never exceeds 1, overflow=0.
REQ-038 Clear collision and reset: with overflow=1, assert clr_ovf together with a rejected write -> overflow=1, dropped=1; then rst with wr_en=1 -> count=0, overflow=0.
